// File: rtl/vga_sprite_display.sv
// vga_sprite_display
//   Scans a 640x480@60 VGA raster (800x525 total) and paints one filled
//   rectangular sprite, a ground band along the bottom and a flat background
//   as 12-bit RGB444. The sprite position coming from the bounce logic is
//   captured once per frame at the start of vertical blanking, so a frame is
//   never drawn with a half-updated position; frame_tick marks that moment so
//   game logic can pace itself to the display.
//
//   The raster geometry is parameterised (defaults give standard 640x480@60)
//   so the same block can drive a reduced raster when that is convenient.
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   x           in  10   sprite left column, sampled once per frame
//   y           in   9   sprite top line, sampled once per frame
//   hsync       out  1   horizontal sync, active low, registered
//   vsync       out  1   vertical sync, active low, registered
//   rgb         out 12   pixel colour {R,G,B}, registered, 0 when blanked
//   video_on    out  1   registered pixel lies in the visible area
//   frame_tick  out  1   one-clk pulse at start of vertical blanking
module vga_sprite_display #(
  parameter int          CLK_DIV      = 4,
  parameter int          SPRITE_W     = 16,
  parameter int          SPRITE_H     = 16,
  parameter int          GROUND_Y     = 440,
  parameter logic [11:0] SPRITE_COLOR = 12'hF00,
  parameter logic [11:0] GROUND_COLOR = 12'h0A0,
  parameter logic [11:0] BG_COLOR     = 12'h00F,
  parameter int          H_VISIBLE    = 640,
  parameter int          H_FRONT      = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BACK       = 48,
  parameter int          V_VISIBLE    = 480,
  parameter int          V_FRONT      = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BACK       = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        video_on,
  output logic        frame_tick
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_GROUND = 10'(GROUND_Y);

  // Largest positions that still keep the whole sprite on screen.
  localparam logic [9:0]  SX_MAX  = 10'(H_VISIBLE - SPRITE_W);
  localparam logic [8:0]  SY_MAX  = 9'(V_VISIBLE - SPRITE_H);
  localparam logic [10:0] SPR_W11 = 11'(SPRITE_W);
  localparam logic [10:0] SPR_H11 = 11'(SPRITE_H);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       sx;
  logic [8:0]       sy;
  logic             at_latch;
  logic             visible;
  logic             in_sprite;
  logic [10:0]      h11, v11, sx11, sy11;
  logic [11:0]      pixel_color;

  // Pixel-rate enable; with CLK_DIV=1 DIV_LAST is 0 and tick is always high.
  assign tick = (div_cnt == DIV_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // First pixel of vertical blanking: take the new position here so the whole
  // next frame is drawn from one consistent (x,y).
  assign at_latch = tick && (h_cnt == '0) && (v_cnt == V_VIS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx         <= '0;
      sy         <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= at_latch;
      if (at_latch) begin
        sx <= (x > SX_MAX) ? SX_MAX : x;
        sy <= (y > SY_MAX) ? SY_MAX : y;
      end
    end
  end

  // NOTE: every signal driven here gets a value on every path (defaults
  // first), so no latches are inferred.
  always_comb begin
    // Bounds are compared one bit wider so sx+SPRITE_W cannot wrap.
    h11       = {1'b0, h_cnt};
    v11       = {1'b0, v_cnt};
    sx11      = {1'b0, sx};
    sy11      = {2'b00, sy};
    visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    in_sprite = (h11 >= sx11) && (h11 < sx11 + SPR_W11) &&
                (v11 >= sy11) && (v11 < sy11 + SPR_H11);
    pixel_color = 12'h000;
    if (visible) begin
      if (in_sprite)              pixel_color = SPRITE_COLOR;
      else if (v_cnt >= V_GROUND) pixel_color = GROUND_COLOR;
      else                        pixel_color = BG_COLOR;
    end
  end

  // One-tick output pipeline, driven from the pre-increment counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      rgb      <= 12'h000;
      video_on <= 1'b0;
    end else if (tick) begin
      hsync    <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
      vsync    <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
      rgb      <= pixel_color;
      video_on <= visible;
    end
  end

endmodule

// File: tb/tb_vga_sprite_display.sv
// Bench for vga_sprite_display.
//   dut_full : default 640x480 raster, CLK_DIV=1 -- line timing, first-frame
//              sprite at (0,0), asynchronous reset mid-line.
//   dut_small: reduced raster (56x42 total, 48x36 visible), CLK_DIV=2 --
//              frame timing, position latching, clamping, random x/y against
//              a reference model computed from pixel index arithmetic.
module tb_vga_sprite_display;

  localparam int S_DIV = 2;
  localparam int S_HV = 48, S_HF = 2, S_HS = 4, S_HB = 2;
  localparam int S_VV = 36, S_VF = 2, S_VS = 2, S_VB = 2;
  localparam int S_GY = 30;
  localparam int SPR  = 16;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;   // 56
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;   // 42
  localparam int S_FRAME = S_HT * S_VT * S_DIV;      // 4704 clks

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_f = 1'b1, rst_s = 1'b1;
  logic [9:0]  x_f = 10'd0, x_s = 10'd0;
  logic [8:0]  y_f = 9'd0, y_s = 9'd0;
  logic        hs_f, vs_f, von_f, ft_f;
  logic [11:0] rgb_f;
  logic        hs_s, vs_s, von_s, ft_s;
  logic [11:0] rgb_s;

  int errors = 0;
  int checks = 0;

  vga_sprite_display #(.CLK_DIV(1)) dut_full (
    .clk(clk), .rst(rst_f), .x(x_f), .y(y_f),
    .hsync(hs_f), .vsync(vs_f), .rgb(rgb_f), .video_on(von_f), .frame_tick(ft_f)
  );

  vga_sprite_display #(
    .CLK_DIV(S_DIV), .GROUND_Y(S_GY),
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) dut_small (
    .clk(clk), .rst(rst_s), .x(x_s), .y(y_s),
    .hsync(hs_s), .vsync(vs_s), .rgb(rgb_s), .video_on(von_s), .frame_tick(ft_s)
  );

  // ---------------- reference model for dut_small ----------------
  // Clock edge n after reset carries pixel index n/DIV-1 when n%DIV==0;
  // (h,v) follow from that index by division. Position comes from the
  // x/y seen at the first blanking pixel of each frame.
  function automatic logic [11:0] ref_color(int h, int v, int px, int py);
    if (h >= S_HV || v >= S_VV) return 12'h000;
    if (h >= px && h < px + SPR && v >= py && v < py + SPR) return 12'hF00;
    if (v >= S_GY) return 12'h0A0;
    return 12'h00F;
  endfunction

  function automatic int clamp(int val, int hi);
    return (val > hi) ? hi : val;
  endfunction

  int          m_edges, m_k, m_h, m_v, m_sx, m_sy, m_latches;
  logic        m_fresh, m_hs, m_vs, m_von, m_ft;
  logic [11:0] m_rgb;

  always @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      m_edges = 0; m_h = 0; m_v = 0; m_sx = 0; m_sy = 0;
      m_fresh = 0; m_hs = 1; m_vs = 1; m_von = 0; m_ft = 0; m_rgb = 12'h000;
    end else begin
      m_edges++;
      m_fresh = 0;
      m_ft    = 0;
      if (m_edges % S_DIV == 0) begin
        m_k     = m_edges / S_DIV - 1;
        m_h     = m_k % S_HT;
        m_v     = (m_k / S_HT) % S_VT;
        m_fresh = 1;
        m_hs    = !(m_h >= S_HV + S_HF && m_h < S_HV + S_HF + S_HS);
        m_vs    = !(m_v >= S_VV + S_VF && m_v < S_VV + S_VF + S_VS);
        m_von   = (m_h < S_HV) && (m_v < S_VV);
        m_rgb   = ref_color(m_h, m_v, m_sx, m_sy);
        if (m_h == 0 && m_v == S_VV) begin
          m_ft  = 1;
          m_sx  = clamp(int'(x_s), S_HV - SPR);
          m_sy  = clamp(int'(y_s), S_VV - SPR);
          m_latches++;
        end
      end
    end
  end

  // Continuous comparison of every dut_small output against the model.
  bit    mon_en = 0;
  int    mon_bad = 0;
  string mon_first = "";
  always @(negedge clk) begin
    if (mon_en && !rst_s) begin
      if ({hs_s, vs_s, rgb_s, von_s, ft_s} !== {m_hs, m_vs, m_rgb, m_von, m_ft}) begin
        if (mon_bad == 0)
          mon_first = $sformatf("edge=%0d h=%0d v=%0d dut hs/vs/rgb/von/ft=%b/%b/%h/%b/%b model=%b/%b/%h/%b/%b",
                                m_edges, m_h, m_v, hs_s, vs_s, rgb_s, von_s, ft_s,
                                m_hs, m_vs, m_rgb, m_von, m_ft);
        mon_bad++;
      end
    end
  end

  task automatic wait_pix_s(input int h, input int v, output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      @(negedge clk);
      if (!rst_s && m_fresh && m_h == h && m_v == v) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_latch_s(output bit ok);
    int start;
    start = m_latches;
    ok = 0;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      @(negedge clk);
      if (m_latches != start) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- dut_full tests ----------------
  task automatic test_reset_full();
    @(negedge clk);
    checks++;
    if ({hs_f, vs_f, rgb_f, von_f, ft_f} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_full: hs/vs/rgb/von/ft=%b/%b/%h/%b/%b expected 1/1/000/0/0",
               hs_f, vs_f, rgb_f, von_f, ft_f);
    end
  endtask

  task automatic test_full_timing();
    int          first = -1, width = 0, period = -1, falls = 0;
    logic        prev = 1'b1;
    int          pe[6];
    logic [12:0] pexp[6];
    pe   = '{1, 17, 641, 12016, 12801, 13121};
    // {rgb, video_on} for pixels (0,0) (16,0) (640,0) (15,15) (0,16) (320,16)
    pexp = '{{12'hF00, 1'b1}, {12'h00F, 1'b1}, {12'h000, 1'b0},
             {12'hF00, 1'b1}, {12'h00F, 1'b1}, {12'h00F, 1'b1}};
    rst_f = 1'b0;
    for (int e = 1; e <= 13121; e++) begin
      @(negedge clk);
      if (prev === 1'b1 && hs_f === 1'b0) begin
        falls++;
        if (falls == 1) first = e;
        else if (falls == 2) period = e - first;
      end
      if (falls == 1 && hs_f === 1'b0) width++;
      prev = hs_f;
      for (int j = 0; j < 6; j++) begin
        if (e == pe[j]) begin
          checks++;
          if ({rgb_f, von_f} !== pexp[j]) begin
            errors++;
            $display("FAIL full_pixel edge %0d: rgb=%h von=%b expected rgb=%h von=%b",
                     e, rgb_f, von_f, pexp[j][12:1], pexp[j][0]);
          end
        end
      end
    end
    checks++;
    if (first !== 657) begin errors++; $display("FAIL hsync_first: edge %0d expected 657", first); end
    checks++;
    if (width !== 96) begin errors++; $display("FAIL hsync_width: %0d clks expected 96", width); end
    checks++;
    if (period !== 800) begin errors++; $display("FAIL hsync_period: %0d clks expected 800", period); end
  endtask

  // Called right after the negedge that shows pixel (320,16).
  task automatic test_full_reset();
    int   first = -1, width = 0, falls = 0;
    logic prev = 1'b1;
    rst_f = 1'b1;
    #1;
    checks++;
    if ({hs_f, vs_f, rgb_f, von_f} !== {1'b1, 1'b1, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL full_async_reset: hs/vs/rgb/von=%b/%b/%h/%b expected 1/1/000/0",
               hs_f, vs_f, rgb_f, von_f);
    end
    repeat (3) @(negedge clk);
    rst_f = 1'b0;
    for (int e = 1; e <= 1500; e++) begin
      @(negedge clk);
      if (prev === 1'b1 && hs_f === 1'b0) begin
        falls++;
        if (falls == 1) first = e;
      end
      if (falls == 1 && hs_f === 1'b0) width++;
      prev = hs_f;
      if (e == 1) begin
        checks++;
        if (rgb_f !== 12'hF00) begin
          errors++;
          $display("FAIL full_restart_pixel00: rgb=%h expected f00", rgb_f);
        end
      end
    end
    checks++;
    if (first !== 657) begin errors++; $display("FAIL hsync_first_after_reset: edge %0d expected 657", first); end
    checks++;
    if (width !== 96) begin errors++; $display("FAIL hsync_width_after_reset: %0d expected 96", width); end
  endtask

  // ---------------- dut_small tests ----------------
  task automatic test_reset_small();
    bit          ok;
    int          ph[3], pv[3];
    logic [11:0] pc[3];
    @(negedge clk);
    checks++;
    if ({hs_s, vs_s, rgb_s, von_s, ft_s} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_small: hs/vs/rgb/von/ft=%b/%b/%h/%b/%b expected 1/1/000/0/0",
               hs_s, vs_s, rgb_s, von_s, ft_s);
    end
    rst_s  = 1'b0;
    mon_en = 1;
    ph = '{0, 16, 15};
    pv = '{0, 0, 15};
    pc = '{12'hF00, 12'h00F, 12'hF00};
    for (int i = 0; i < 3; i++) begin
      wait_pix_s(ph[i], pv[i], ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL first_frame (%0d,%0d): pixel not reached", ph[i], pv[i]);
      end else if (rgb_s !== pc[i]) begin
        errors++; $display("FAIL first_frame (%0d,%0d): rgb=%h expected %h", ph[i], pv[i], rgb_s, pc[i]);
      end
    end
  endtask

  task automatic test_frame_timing();
    int   vs_falls = 0, vs_first = -1, vs_width = 0, vs_period = -1;
    int   ft_rises = 0, ft_first = -1, ft_width = 0, ft_period = -1, ft_abs = -1;
    logic vs_prev = 1'b1, ft_prev = 1'b0;
    for (int e = 0; e < 3 * S_FRAME; e++) begin
      @(negedge clk);
      if (vs_prev === 1'b1 && vs_s === 1'b0) begin
        vs_falls++;
        if (vs_falls == 1) vs_first = e;
        else if (vs_falls == 2) vs_period = e - vs_first;
      end
      if (vs_falls == 1 && vs_s === 1'b0) vs_width++;
      if (ft_prev === 1'b0 && ft_s === 1'b1) begin
        ft_rises++;
        if (ft_rises == 1) begin ft_first = e; ft_abs = m_edges; end
        else if (ft_rises == 2) ft_period = e - ft_first;
      end
      if (ft_rises == 1 && ft_s === 1'b1) ft_width++;
      vs_prev = vs_s;
      ft_prev = ft_s;
      if (vs_falls >= 2 && ft_rises >= 2) break;
    end
    checks++;
    if (vs_width !== 2 * S_HT * S_DIV) begin
      errors++; $display("FAIL vsync_width: %0d clks expected %0d", vs_width, 2 * S_HT * S_DIV);
    end
    checks++;
    if (vs_period !== S_FRAME) begin
      errors++; $display("FAIL vsync_period: %0d clks expected %0d", vs_period, S_FRAME);
    end
    checks++;
    if (ft_width !== 1) begin
      errors++; $display("FAIL frame_tick_width: %0d clks expected 1", ft_width);
    end
    checks++;
    if (ft_period !== S_FRAME) begin
      errors++; $display("FAIL frame_tick_period: %0d clks expected %0d", ft_period, S_FRAME);
    end
    checks++;
    if (ft_abs !== (S_VV * S_HT + 1) * S_DIV) begin
      errors++; $display("FAIL frame_tick_first: edge %0d expected %0d", ft_abs, (S_VV * S_HT + 1) * S_DIV);
    end
  endtask

  task automatic test_sprite_pixels();
    bit          ok;
    int          ph[6], pv[6];
    logic [11:0] pc[6];
    x_s = 10'd10;
    y_s = 9'd4;
    wait_latch_s(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pixels_latch: no latch seen"); end
    // Sprite covers columns 10..25, lines 4..19; ground from line 30.
    ph = '{9, 10, 26, 25, 20, 52};
    pv = '{4, 4, 4, 19, 32, 33};
    pc = '{12'h00F, 12'hF00, 12'h00F, 12'hF00, 12'h0A0, 12'h000};
    for (int i = 0; i < 6; i++) begin
      wait_pix_s(ph[i], pv[i], ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL pixels (%0d,%0d): pixel not reached", ph[i], pv[i]);
      end else if (rgb_s !== pc[i]) begin
        errors++; $display("FAIL pixels (%0d,%0d): rgb=%h expected %h", ph[i], pv[i], rgb_s, pc[i]);
      end
    end
    checks++;
    if ({von_s, hs_s} !== 2'b00) begin
      errors++; $display("FAIL blank_pixel (52,33): von=%b hsync=%b expected 0/0", von_s, hs_s);
    end
  endtask

  task automatic test_move_midframe();
    bit          ok;
    int          ph[4], pv[4];
    logic [11:0] pc[4];
    wait_pix_s(0, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL move_sync: pixel (0,10) not reached"); end
    x_s = 10'd30;
    // Rest of this frame keeps column 10; the next frame moves to 30.
    ph = '{10, 30, 10, 30};
    pv = '{12, 12, 12, 12};
    pc = '{12'hF00, 12'h00F, 12'h00F, 12'hF00};
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        wait_latch_s(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL move_latch: no latch seen"); end
      end
      wait_pix_s(ph[i], pv[i], ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL move step %0d (%0d,%0d): pixel not reached", i, ph[i], pv[i]);
      end else if (rgb_s !== pc[i]) begin
        errors++; $display("FAIL move step %0d (%0d,%0d): rgb=%h expected %h", i, ph[i], pv[i], rgb_s, pc[i]);
      end
    end
  endtask

  task automatic test_clamp();
    bit          ok;
    int          ph[7], pv[7];
    logic [11:0] pc[7];
    x_s = 10'd1023;
    y_s = 9'd511;
    wait_latch_s(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clamp_latch: no latch seen"); end
    // Clamped to columns 32..47, lines 20..35; overlaps ground from line 30.
    ph = '{0, 47, 0, 32, 48, 31, 47};
    pv = '{0, 19, 20, 20, 20, 35, 35};
    pc = '{12'h00F, 12'h00F, 12'h00F, 12'hF00, 12'h000, 12'h0A0, 12'hF00};
    for (int i = 0; i < 7; i++) begin
      wait_pix_s(ph[i], pv[i], ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL clamp (%0d,%0d): pixel not reached", ph[i], pv[i]);
      end else if (rgb_s !== pc[i]) begin
        errors++; $display("FAIL clamp (%0d,%0d): rgb=%h expected %h", ph[i], pv[i], rgb_s, pc[i]);
      end
    end
  endtask

  task automatic test_random_positions();
    int b0, left, n;
    b0   = mon_bad;
    left = 3 * S_FRAME;
    while (left > 0) begin
      n   = $urandom_range(50, 600);
      x_s = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 40));
      y_s = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 28));
      repeat (n) @(negedge clk);
      left -= n;
    end
    checks++;
    if (mon_bad - b0 !== 0) begin
      errors++;
      $display("FAIL random_vs_model: %0d clks differ, first: %s", mon_bad - b0, mon_first);
    end
  endtask

  task automatic test_reset_small_midframe();
    bit   ok;
    int   first = -1, width = 0, period = -1, falls = 0;
    logic prev = 1'b1;
    wait_pix_s(51, 38, ok);
    checks++;
    if (!ok || {hs_s, vs_s} !== 2'b00) begin
      errors++; $display("FAIL pre_reset_sync: reached=%0b hs=%b vs=%b expected 1/0/0", ok, hs_s, vs_s);
    end
    mon_en = 0;
    rst_s  = 1'b1;
    #1;
    checks++;
    if ({hs_s, vs_s, rgb_s, von_s, ft_s} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL small_async_reset: hs/vs/rgb/von/ft=%b/%b/%h/%b/%b expected 1/1/000/0/0",
               hs_s, vs_s, rgb_s, von_s, ft_s);
    end
    repeat (3) @(negedge clk);
    rst_s  = 1'b0;
    mon_en = 1;
    for (int e = 1; e <= 400; e++) begin
      @(negedge clk);
      if (prev === 1'b1 && hs_s === 1'b0) begin
        falls++;
        if (falls == 1) first = e;
        else if (falls == 2) period = e - first;
      end
      if (falls == 1 && hs_s === 1'b0) width++;
      prev = hs_s;
    end
    checks++;
    if (first !== (S_HV + S_HF + 1) * S_DIV) begin
      errors++; $display("FAIL small_hsync_first: edge %0d expected %0d", first, (S_HV + S_HF + 1) * S_DIV);
    end
    checks++;
    if (width !== S_HS * S_DIV) begin
      errors++; $display("FAIL small_hsync_width: %0d expected %0d", width, S_HS * S_DIV);
    end
    checks++;
    if (period !== S_HT * S_DIV) begin
      errors++; $display("FAIL small_hsync_period: %0d expected %0d", period, S_HT * S_DIV);
    end
  endtask

  initial begin
    test_reset_full();
    test_full_timing();
    test_full_reset();
    test_reset_small();
    test_frame_timing();
    test_sprite_pixels();
    test_move_midframe();
    test_clamp();
    test_random_positions();
    test_reset_small_midframe();
    checks++;
    if (mon_bad !== 0) begin
      errors++;
      $display("FAIL model_tracking: %0d clks differ, first: %s", mon_bad, mon_first);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
